// File: rtl/execute_mul_pkg.sv
// Shared definitions for the pipelined execute-stage multiplier.
// Contents: command codes, flag bit positions and the packed flag struct.
package execute_mul_pkg;

    localparam logic [4:0] EXE_MUL_MUL   = 5'd0;
    localparam logic [4:0] EXE_MUL_MULH  = 5'd1;
    localparam logic [4:0] EXE_MUL_UMULH = 5'd2;
    localparam logic [4:0] EXE_MUL_RAND  = 5'd3;

    // Bit positions inside the 5-bit {SF, OF, CF, PF, ZF} flag vector
    localparam int unsigned FLAG_ZF = 0;
    localparam int unsigned FLAG_PF = 1;
    localparam int unsigned FLAG_CF = 2;
    localparam int unsigned FLAG_OF = 3;
    localparam int unsigned FLAG_SF = 4;

    typedef struct packed {
        logic sf;
        logic of;
        logic cf;
        logic pf;
        logic zf;
    } mul_flags_t;

endpackage

// File: rtl/execute_mul_flags.sv
// Result select and flag generation from a full double-width product.
// Ports:
//   prod_i    full 2*DATA_W product
//   hi_sel_i  1: return high half (MULH/UMULH), 0: return low half (MUL)
//   data_o    selected result half
//   flags_o   {SF, OF, CF, PF, ZF}
module execute_mul_flags
    import execute_mul_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] prod_i,
    input  logic                hi_sel_i,
    output logic [DATA_W-1:0]   data_o,
    output mul_flags_t          flags_o
);

    always_comb begin
        data_o     = prod_i[DATA_W-1:0];
        flags_o    = '0;
        // Zero reflects the whole product, not just the returned half
        flags_o.zf = (prod_i == '0);
        if (hi_sel_i) begin
            data_o     = prod_i[2*DATA_W-1:DATA_W];
            flags_o.sf = prod_i[2*DATA_W-1];
            flags_o.pf = prod_i[DATA_W];
        end else begin
            flags_o.sf = prod_i[DATA_W-1];
            flags_o.cf = prod_i[DATA_W];
            flags_o.of = prod_i[DATA_W-1] ^ prod_i[DATA_W];
            flags_o.pf = prod_i[0];
        end
    end

endmodule

// File: rtl/execute_mul_pipe.sv
// Pipelined multiply unit for the execute stage.
// The product is formed in front of stage 1; the remaining LATENCY-1 stages are plain delay
// registers sharing one stall enable (stall = oVALID & iNEXT_BUSY), so bubbles are kept.
// Optional feature: define MIST32_MUL_RAND_EN to make EXE_MUL_RAND return xorshift32(iDATA_1)
// with zero flags (DATA_W must then be 32); otherwise EXE_MUL_RAND decodes as MUL.
// Ports:
//   iCLOCK, iRESET (async, active high), iFLUSH (sync, drops all in-flight ops)
//   iVALID/oBUSY         issue handshake; iCMD, iTAG, iDATA_0, iDATA_1 operands
//   oVALID/iNEXT_BUSY    result handshake; oTAG, oDATA, oFLAGS registered result
// LATENCY must be in 1..4; DATA_W >= 8.
module execute_mul_pipe
    import execute_mul_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 6
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    input  logic              iFLUSH,
    input  logic              iVALID,
    output logic              oBUSY,
    input  logic [4:0]        iCMD,
    input  logic [TAG_W-1:0]  iTAG,
    input  logic [DATA_W-1:0] iDATA_0,
    input  logic [DATA_W-1:0] iDATA_1,
    output logic              oVALID,
    input  logic              iNEXT_BUSY,
    output logic [TAG_W-1:0]  oTAG,
    output logic [DATA_W-1:0] oDATA,
    output logic [4:0]        oFLAGS
);

    localparam int unsigned PW = 2 * DATA_W;

    logic              stall;
    logic              hi_sel;
    logic [PW-1:0]     prod_u;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] res_data;
    mul_flags_t        res_flags;
    logic [DATA_W-1:0] st_data;
    mul_flags_t        st_flags;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]  data_q  [LATENCY];
    logic [DATA_W-1:0]  data_d  [LATENCY];
    mul_flags_t         flags_q [LATENCY];
    mul_flags_t         flags_d [LATENCY];
    logic [TAG_W-1:0]   tag_q   [LATENCY];
    logic [TAG_W-1:0]   tag_d   [LATENCY];

    // Both products are formed at full width so no truncation happens before selection
    assign prod_u = {{DATA_W{1'b0}}, iDATA_0} * {{DATA_W{1'b0}}, iDATA_1};
    assign prod_s = $unsigned($signed({{DATA_W{iDATA_0[DATA_W-1]}}, iDATA_0}) *
                              $signed({{DATA_W{iDATA_1[DATA_W-1]}}, iDATA_1}));

    // Anything not MULH/UMULH (including unknown codes) behaves as MUL
    always_comb begin
        hi_sel = 1'b0;
        prod   = prod_u;
        case (iCMD)
            EXE_MUL_MULH: begin
                hi_sel = 1'b1;
                prod   = prod_s;
            end
            EXE_MUL_UMULH: hi_sel = 1'b1;
            default: ;
        endcase
    end

    execute_mul_flags #(
        .DATA_W (DATA_W)
    ) u_flags (
        .prod_i   (prod),
        .hi_sel_i (hi_sel),
        .data_o   (res_data),
        .flags_o  (res_flags)
    );

`ifdef MIST32_MUL_RAND_EN
    logic [DATA_W-1:0] rnd_a;
    logic [DATA_W-1:0] rnd_b;
    logic [DATA_W-1:0] rnd_c;

    assign rnd_a = iDATA_1 ^ (iDATA_1 << 13);
    assign rnd_b = rnd_a ^ (rnd_a >> 17);
    assign rnd_c = rnd_b ^ (rnd_b << 5);

    always_comb begin
        st_data  = res_data;
        st_flags = res_flags;
        if (iCMD == EXE_MUL_RAND) begin
            st_data  = rnd_c;
            st_flags = '0;
        end
    end
`else
    assign st_data  = res_data;
    assign st_flags = res_flags;
`endif

    assign stall = vld_q[LATENCY-1] & iNEXT_BUSY;

    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        flags_d = flags_q;
        tag_d   = tag_q;
        if (!stall) begin
            // oBUSY equals stall, so when shifting every presented op is accepted
            vld_d[0]   = iVALID;
            data_d[0]  = st_data;
            flags_d[0] = st_flags;
            tag_d[0]   = iTAG;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_d[i]   = vld_q[i-1];
                data_d[i]  = data_q[i-1];
                flags_d[i] = flags_q[i-1];
                tag_d[i]   = tag_q[i-1];
            end
        end
        // Flush wins over both stall and a same-cycle accept
        if (iFLUSH) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i]  <= '0;
                flags_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            tag_q   <= tag_d;
        end
    end

    assign oBUSY  = stall;
    assign oVALID = vld_q[LATENCY-1];
    assign oDATA  = data_q[LATENCY-1];
    assign oTAG   = tag_q[LATENCY-1];
    assign oFLAGS = flags_q[LATENCY-1];

endmodule
